// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
//   state_t       : responder FSM states
//   dmem_req_t    : captured request payload (write flag, byte address, write data)
//   is_misaligned : true when a byte address is not word aligned
package dmem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

  // Word accesses only: any nonzero byte offset is an error.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32-bit word RAM: synchronous write, asynchronous read by index.
// Ports:
//   clk     : write clock
//   wr_en   : write strobe, sampled on rising clk
//   wr_idx  : word index to write
//   wr_data : word to write
//   rd_idx  : word index to read
//   rd_data : word at rd_idx (combinational)
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Storage has no reset; contents survive responder resets.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: accepts one request at a time, answers
// after LATENCY wait states with a one-cycle response, and stalls the pipeline
// while a request is outstanding.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : request present (read or write)
//   req_write   : 1 = write, 0 = read
//   req_addr    : byte address; index wraps modulo DEPTH_WORDS
//   req_wdata   : write data
//   req_ready   : responder idle and able to accept
//   resp_valid  : one-cycle response pulse
//   resp_rdata  : read data (0 for writes, errors and outside the response)
//   resp_err    : request was misaligned (with resp_valid)
//   stall       : combinational pipeline freeze
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 4;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         req_q, req_d;

  logic              req_ready_d;
  logic              resp_valid_d;
  logic              resp_err_d;
  logic [WORD_W-1:0] resp_rdata_d;

  logic [WORD_W-1:0] rd_word;
  logic              wr_en_c;
  logic              unused_addr_hi;

  // Next state, counter and capture; outputs are precomputed from the next
  // state so they are registered yet line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.write = req_write;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          cnt_d       = CNT_W'(LATENCY);
          state_d     = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = resp_valid_d && is_misaligned(req_d.addr);
    // The array cannot change before the response cycle, so reading it one
    // cycle early gives the same word a RESP-cycle read would.
    if (resp_valid_d && !req_d.write && !is_misaligned(req_d.addr)) begin
      resp_rdata_d = rd_word;
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

  // Write lands on the edge that ends the response cycle; misaligned writes are dropped.
  assign wr_en_c = (state_q == RESP) && req_q.write && !is_misaligned(req_q.addr);

  // Low in RESP so the pipeline advances on the response edge.
  assign stall = req_valid && (state_q != RESP);

  // Address bits above the word index are ignored (index wraps).
  assign unused_addr_hi = ^req_q.addr[WORD_W-1:ADDR_W+2];

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_idx  (req_q.addr[ADDR_W+1:2]),
    .wr_data (req_q.wdata),
    .rd_idx  (req_d.addr[ADDR_W+1:2]),
    .rd_data (rd_word)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=0 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic        req_ready0, resp_valid0, resp_err0, stall0;
  logic [31:0] resp_rdata0;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .req_ready(req_ready0), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
    .resp_err(resp_err0), .stall(stall0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance. mode 1 perturbs the request
  // inputs after acceptance, mode 2 drops req_valid during the wait states.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int mode,
                        input string tag);
    int lat;
    @(negedge clk);
    check({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    #1 check({tag, ":stall_acc"}, 32'(stall), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_valid && lat < 20) begin
        check({tag, ":stall_wait"}, 32'(stall), 32'(req_valid));
        check({tag, ":ready_wait"}, 32'(req_ready), 32'd0);
        if (lat == 1 && mode == 1) begin
          req_addr = addr ^ 32'h4; req_wdata = ~wdata; req_write = ~wr;
        end
        if (lat == 1 && mode == 2) req_valid = 1'b0;
      end
    end while (!resp_valid && lat < 20);
    check({tag, ":latency"}, 32'(lat), 32'd3);
    check({tag, ":rdata"}, resp_rdata, exp_rdata);
    check({tag, ":err"}, 32'(resp_err), 32'(exp_err));
    check({tag, ":stall_resp"}, 32'(stall), 32'd0);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    check({tag, ":valid_after"}, 32'(resp_valid), 32'd0);
    check({tag, ":rdata_after"}, resp_rdata, 32'd0);
    check({tag, ":ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_mem [4];
    logic [31:0] exp_d;
    bit          got_resp;

    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_valid0 = 0; req_write0 = 0; req_addr0 = '0; req_wdata0 = '0;
    repeat (2) @(negedge clk);
    check("rst:ready", 32'(req_ready), 32'd1);
    check("rst:valid", 32'(resp_valid), 32'd0);
    check("rst:rdata", resp_rdata, 32'd0);
    check("rst:err", 32'(resp_err), 32'd0);
    check("rst:stall", 32'(stall), 32'd0);
    check("rst0:ready", 32'(req_ready0), 32'd1);
    check("rst0:valid", 32'(resp_valid0), 32'd0);
    rst = 1'b0;

    // Write then read back.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "wr10");
    do_req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "rd10");

    // Misaligned write is suppressed; misaligned read returns 0.
    do_req(1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 0, "wr20");
    do_req(1'b1, 32'h22, 32'h12345678, 32'h0, 1'b1, 0, "wrmis");
    do_req(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0, "rd20");
    do_req(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 0, "rdmis");

    // Index wraps modulo DEPTH_WORDS.
    do_req(1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0, 0, "wr400");
    do_req(1'b0, 32'h000, 32'h0, 32'hA5A5A5A5, 1'b0, 0, "rd000");

    // Inputs changed after acceptance are ignored.
    do_req(1'b1, 32'h34, 32'h0, 32'h0, 1'b0, 0, "wr34");
    do_req(1'b1, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 1, "wr30scr");
    do_req(1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 0, "rd30");
    do_req(1'b0, 32'h34, 32'h0, 32'h0, 1'b0, 0, "rd34");

    // req_valid dropped during wait still completes the read.
    do_req(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "rddrop");

    // Reset mid-wait discards the pending write.
    do_req(1'b1, 32'h40, 32'h22222222, 32'h0, 1'b0, 0, "wr40old");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h11111111;
    @(negedge clk);
    check("rstmid:in_wait", 32'(req_ready), 32'd0);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    #1;
    check("rstmid:ready", 32'(req_ready), 32'd1);
    check("rstmid:stall", 32'(stall), 32'd0);
    got_resp = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) got_resp = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) got_resp = 1'b1;
    end
    check("rstmid:no_resp", 32'(got_resp), 32'd0);
    check("rstmid:err", 32'(resp_err), 32'd0);
    check("rstmid:rdata", resp_rdata, 32'd0);
    do_req(1'b0, 32'h40, 32'h0, 32'h22222222, 1'b0, 0, "rd40");

    // LATENCY=0: a request every 2 cycles with req_valid held throughout.
    for (int i = 0; i < 4; i++) exp_mem[i] = 32'h1000_0000 + 32'(i * 16'h1111);
    @(negedge clk);
    req_valid0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_write0 = (i < 4);
      req_addr0  = 32'((i % 4) * 4);
      req_wdata0 = (i < 4) ? exp_mem[i % 4] : 32'h0;
      #1;
      check($sformatf("l0:%0d:ready", i), 32'(req_ready0), 32'd1);
      check($sformatf("l0:%0d:stall_acc", i), 32'(stall0), 32'd1);
      @(negedge clk);
      exp_d = (i < 4) ? 32'h0 : exp_mem[i % 4];
      check($sformatf("l0:%0d:valid", i), 32'(resp_valid0), 32'd1);
      check($sformatf("l0:%0d:rdata", i), resp_rdata0, exp_d);
      check($sformatf("l0:%0d:err", i), 32'(resp_err0), 32'd0);
      check($sformatf("l0:%0d:stall_resp", i), 32'(stall0), 32'd0);
      @(negedge clk);
      check($sformatf("l0:%0d:valid_off", i), 32'(resp_valid0), 32'd0);
    end
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    @(negedge clk);
    check("l0:idle_valid", 32'(resp_valid0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
